// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_DIV   = 4;
  localparam int unsigned MIN_DIV   = 2;

  // First count value at which the divided clock is high; low phase is the longer half.
  function automatic int unsigned hi_threshold(input int unsigned n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: counter, active/shadow divisor, glitch-free start/stop and apply.
module clock_divider_chan
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_busy
);

  logic [WIDTH-1:0] r_cnt, r_div, r_shadow;
  logic             r_pending, r_running, r_clk, r_tick;

  logic [WIDTH-1:0] w_cnt_nxt, w_div_nxt, w_shadow_nxt;
  logic             w_pending_nxt, w_running_nxt, w_clk_nxt, w_tick_nxt;
  logic [WIDTH-1:0] w_div_eff, w_step_div, w_step, w_hi;
  logic             w_wrap, w_legal;

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_running_nxt = r_running;
    w_clk_nxt     = 1'b0;
    w_tick_nxt    = 1'b0;

    w_div_eff  = r_pending ? r_shadow : r_div;
    w_legal    = (w_div_eff >= WIDTH'(MIN_DIV));
    // A stopped channel starts with whatever divisor is being applied on this edge.
    w_step_div = r_running ? r_div : w_div_eff;
    w_step     = (r_cnt == w_step_div - 1'b1) ? '0 : r_cnt + 1'b1;
    w_wrap     = (w_step == '0);
    w_hi       = WIDTH'(hi_threshold(32'(w_step_div)));

    if (i_sync) begin
      w_div_nxt     = w_div_eff;
      w_pending_nxt = 1'b0;
      if (r_running) begin
        w_cnt_nxt     = '0;
        w_tick_nxt    = 1'b1;
        w_running_nxt = i_en && w_legal;
      end
    end else if (r_running) begin
      w_cnt_nxt  = w_step;
      w_clk_nxt  = (w_step >= w_hi);
      w_tick_nxt = w_wrap;
      if (w_wrap) begin
        w_div_nxt     = w_div_eff;
        w_pending_nxt = 1'b0;
        w_running_nxt = i_en && w_legal;
      end
    end else begin
      w_div_nxt     = w_div_eff;
      w_pending_nxt = 1'b0;
      if (i_en && w_legal) begin
        w_running_nxt = 1'b1;
        w_cnt_nxt     = w_step;
        w_clk_nxt     = (w_step >= w_hi);
        w_tick_nxt    = w_wrap;
      end
    end

    // A new write always lands in the shadow, even on a sync or apply edge.
    if (i_load) begin
      w_shadow_nxt  = i_load_div;
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_cnt     <= '0;
      r_div     <= WIDTH'(DEFAULT_DIV);
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_running <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_running <= w_running_nxt;
      r_clk     <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_busy = r_pending;

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: NCH channels sharing one config port.
module clock_divider_mc
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned NCH         = DEF_NCH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  parameter int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_chan,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  logic [NCH-1:0] w_load;

  // Out-of-range channels stay ready so their writes drain and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (32'(cfg_chan) == 32'(i)) cfg_ready = !busy[i];
    end
  end

  always_comb begin
    w_load = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_load[i] = cfg_valid && cfg_ready && (32'(cfg_chan) == 32'(i));
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    clock_divider_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .i_clk      (clk_in),
      .i_nrst     (nrst),
      .i_en       (en[g]),
      .i_sync     (sync),
      .i_load     (w_load[g]),
      .i_load_div (cfg_div),
      .o_clk      (clk_out[g]),
      .o_tick     (tick[g]),
      .o_busy     (busy[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Self-checking bench: timestamp-based reference model plus directed literal checks.
module tb_clock_divider_mc;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int CHW   = 2;

  logic             clk_in = 1'b0;
  logic             nrst, cfg_valid, cfg_ready, sync;
  logic [NCH-1:0]   en, clk_out, tick, busy;
  logic [CHW-1:0]   cfg_chan;
  logic [WIDTH-1:0] cfg_div;

  always #5 clk_in = ~clk_in;

  clock_divider_mc #(
    .WIDTH       (WIDTH),
    .NCH         (NCH),
    .DEFAULT_DIV (4),
    .CHW         (CHW)
  ) dut (
    .clk_in    (clk_in),
    .nrst      (nrst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each running channel remembers the edge index at which its
  // count was zero; the phase is the edge distance to that base, modulo N.
  bit             m_valid = 1'b0;
  int             m_e;
  int             m_base [NCH];
  int             m_n [NCH];
  int             m_shadow [NCH];
  bit             m_run [NCH];
  bit             m_pend [NCH];
  bit [NCH-1:0]   m_clk, m_tick;

  always @(posedge clk_in) begin
    bit acc;
    int sel, eff, ph;
    if (!nrst) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_n[c] = 4; m_pend[c] = 0; m_shadow[c] = 0; m_base[c] = 0;
      end
      m_clk = '0; m_tick = '0; m_e = 0; m_valid = 1'b1;
    end else begin
      sel = int'(cfg_chan);
      acc = cfg_valid && ((sel >= NCH) || !m_pend[sel]);
      for (int c = 0; c < NCH; c++) begin
        eff = m_pend[c] ? m_shadow[c] : m_n[c];
        m_clk[c] = 0; m_tick[c] = 0;
        if (sync) begin
          if (m_run[c]) begin
            m_tick[c] = 1; m_base[c] = m_e + 1; m_run[c] = en[c] && (eff >= 2);
          end
          m_n[c] = eff; m_pend[c] = 0;
        end else if (m_run[c]) begin
          ph = (m_e + 1 - m_base[c]) % m_n[c];
          if (ph == 0) begin
            m_tick[c] = 1; m_n[c] = eff; m_pend[c] = 0;
            m_run[c] = en[c] && (eff >= 2); m_base[c] = m_e + 1;
          end else begin
            m_clk[c] = (ph >= m_n[c] - m_n[c] / 2);
          end
        end else begin
          m_n[c] = eff; m_pend[c] = 0;
          if (en[c] && eff >= 2) begin
            m_run[c] = 1; m_base[c] = m_e;
            ph = (m_e + 1 - m_base[c]) % eff;
            m_clk[c] = (ph >= eff - eff / 2);
            m_tick[c] = (ph == 0);
          end
        end
        if (acc && sel == c) begin
          m_shadow[c] = int'(cfg_div); m_pend[c] = 1;
        end
      end
      m_e++;
    end
  end

  always @(posedge clk_in) begin
    bit [NCH-1:0] mb;
    #1;
    if (m_valid) begin
      for (int c = 0; c < NCH; c++) mb[c] = m_pend[c];
      chk("model_clk_out", clk_out, m_clk);
      chk("model_tick", tick, m_tick);
      chk("model_busy", busy, mb);
      chk("model_cfg_ready", cfg_ready, !m_pend[int'(cfg_chan)]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #2;
    end
  endtask

  bit e1_clk [8]   = '{0, 1, 1, 0, 0, 1, 1, 0};
  bit e1_tick [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  bit e2_clk [6]   = '{0, 0, 1, 1, 1, 0};
  bit e2_tick [6]  = '{0, 0, 0, 0, 0, 1};
  bit e3_clk [6]   = '{0, 1, 0, 0, 1, 0};
  bit e3_tick [6]  = '{0, 0, 1, 0, 0, 1};
  bit e4_clk [8]   = '{0, 1, 1, 1, 0, 0, 0, 0};
  bit e4_tick [8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
  bit e5_c0 [12]   = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
  bit e5_c1 [12]   = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
  int e6_pair [4]  = '{0, 3, 3, 0};

  initial begin
    nrst = 0; en = '0; cfg_valid = 0; cfg_chan = '0; cfg_div = '0; sync = 0;
    cyc(2);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Default divisor 4 on channel 0
    nrst = 1; en = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t1_clk0", clk_out[0], e1_clk[k]);
      chk("t1_tick0", tick[0], e1_tick[k]);
      chk("t1_idle_chans", clk_out[3:1], 0);
    end
    cyc(12);

    // Divisor change mid-period, second write stalls
    cyc(1);
    cfg_valid = 1; cfg_chan = 0; cfg_div = 6;
    cyc(1);
    chk("t2_busy0", busy[0], 1);
    chk("t2_ready0", cfg_ready, 0);
    cfg_div = 9;
    cyc(1);
    chk("t2_busy0_stall", busy[0], 1);
    chk("t2_ready0_stall", cfg_ready, 0);
    cfg_valid = 0;
    cyc(1);
    chk("t2_wrap_tick0", tick[0], 1);
    chk("t2_busy0_clear", busy[0], 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("t2_clk0_n6", clk_out[0], e2_clk[k]);
      chk("t2_tick0_n6", tick[0], e2_tick[k]);
    end

    // Odd divisor on a stopped channel
    cfg_valid = 1; cfg_chan = 1; cfg_div = 3;
    cyc(1);
    chk("t3_busy1", busy[1], 1);
    cfg_valid = 0;
    cyc(1);
    chk("t3_busy1_applied", busy[1], 0);
    en = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("t3_clk1_n3", clk_out[1], e3_clk[k]);
      chk("t3_tick1_n3", tick[1], e3_tick[k]);
    end

    // Enable dropped mid-period completes the period
    cfg_valid = 1; cfg_chan = 2; cfg_div = 6;
    cyc(1);
    cfg_valid = 0;
    cyc(1);
    en = 4'b0111;
    cyc(1);
    chk("t4_clk2_start", clk_out[2], 0);
    en = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t4_clk2_stop", clk_out[2], e4_clk[k]);
      chk("t4_tick2_stop", tick[2], e4_tick[k]);
    end

    // Illegal divisor stops a running channel at its wrap
    cfg_valid = 1; cfg_chan = 1; cfg_div = 1;
    cyc(1);
    cfg_valid = 0;
    cyc(6);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t4_clk1_illegal", clk_out[1], 0);
      chk("t4_tick1_illegal", tick[1], 0);
    end
    chk("t4_busy1_illegal", busy[1], 0);

    // Phase align N=4 and N=6
    cfg_valid = 1; cfg_chan = 0; cfg_div = 4;
    cyc(1);
    cfg_chan = 1; cfg_div = 6;
    cyc(1);
    cfg_valid = 0;
    cyc(15);
    sync = 1;
    cyc(1);
    sync = 0;
    chk("t5_sync_tick", tick[1:0], 2'b11);
    chk("t5_sync_clk", clk_out[1:0], 2'b00);
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      chk("t5_clk0_aligned", clk_out[0], e5_c0[k % 12]);
      chk("t5_clk1_aligned", clk_out[1], e5_c1[k % 12]);
    end

    // Config write on the same edge as sync stays pending
    cfg_valid = 1; cfg_chan = 0; cfg_div = 8; sync = 1;
    cyc(1);
    cfg_valid = 0; sync = 0;
    chk("t5_sync_cfg_busy0", busy[0], 1);
    chk("t5_sync_cfg_tick0", tick[0], 1);
    cyc(3);
    chk("t5_pending_held", busy[0], 1);
    cyc(1);
    chk("t5_pending_applied", busy[0], 0);
    chk("t5_apply_tick0", tick[0], 1);

    // Reset with a pending write discards it
    cfg_valid = 1; cfg_chan = 1; cfg_div = 10;
    cyc(1);
    cfg_valid = 0;
    chk("t6_busy1_pre", busy[1], 1);
    nrst = 0;
    cyc(1);
    chk("t6_rst_clk_out", clk_out, 0);
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_busy", busy, 0);
    nrst = 1; en = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t6_div_restored", clk_out[1:0], e6_pair[k % 4]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_divider_mc.md
Name: clock_divider_mc

Overview:
Multi-channel programmable clock divider. It is the parametrised successor of the single-channel divider and serves NCH independent divided outputs from one input clock. Each channel has:
- a run-time divisor loaded through a valid/ready config port,
- glitch-free divisor changes applied only at period boundaries,
- a per-channel enable and a global phase-align strobe.

Outputs are registered divided clocks plus period-boundary ticks, for use as clock enables or slow clocks by peripherals.

Parameters:
WIDTH, 8, counter and divisor width; divisor range 2..2^WIDTH-1
NCH, 4, number of output channels
DEFAULT_DIV, 4, divisor loaded into every channel at reset; must be >=2
CHW, $clog2(NCH) (min 1), width of the channel select

Ports:
clk_in  input  1  input clock; all logic on its rising edge
nrst  input  1  reset, synchronous, active-low
en  input  NCH  per-channel run enable
cfg_valid  input  1  config write request
cfg_ready  output  1  config write can be accepted
cfg_chan  input  CHW  target channel of config write
cfg_div  input  WIDTH  new divisor
sync  input  1  one-cycle phase-align strobe, all channels
clk_out  output  NCH  divided clocks, registered
tick  output  NCH  one-cycle pulse per period boundary, registered
busy  output  NCH  channel has a pending divisor not yet applied

Behaviour:
- Reset (nrst=0 at a clk_in edge):
  - per channel: cnt=0, div=DEFAULT_DIV, pending=0, running=0.
  - outputs: clk_out=0, tick=0, busy=0.
- Per running channel with divisor N:
  - cnt_next = (cnt==N-1) ? 0 : cnt+1.
  - clk_out <= (cnt_next >= N-(N>>1)).
  - tick <= (cnt_next==0).
  - Result: period N cycles, high N>>1 cycles, low N-(N>>1) cycles. A period starts low, and the falling edge of clk_out coincides with tick=1.
- Start: a stopped channel with en=1 becomes running at the next edge, counting from cnt=0. For N=4, clk_out rises on the 2nd active edge.
- Stop: en=0 is sampled only on the wrap edge (cnt_next==0). The channel completes its current period, then holds cnt=0, clk_out=0, tick=0. This guarantees no runt pulses.
- Divisor update handshake:
  - A transfer occurs when cfg_valid & cfg_ready at an edge.
  - cfg_ready = !pending[cfg_chan], combinational.
  - A transfer stores cfg_div into shadow[cfg_chan] and sets pending.
  - cfg_chan >= NCH: cfg_ready=1, write is discarded.
- Apply rule:
  - A running channel applies shadow on the first wrap edge strictly after acceptance; the new N is in effect from cnt=0 onward. Acceptance on the same edge as a wrap therefore waits one full period.
  - A stopped channel applies shadow on the next edge.
  - Applying clears pending.
- Illegal divisor: cfg_div < 2 is accepted and applied like any other value. When applied, the channel stops exactly as for en=0 and stays stopped until a legal divisor is applied.
- sync=1 at an edge, for every running channel:
  - cnt<=0, clk_out<=0, tick<=1;
  - pending divisor applied;
  - en=0 channels stop here.
  - Stopped channels are unaffected except that pending is applied.
- Priority: nrst > sync > wrap/apply > count.
- Simultaneous config transfer and sync on the same channel: the new value stays pending; sync applies only the previously pending value.
- busy = pending, registered.
- All channels are independent. No combinational path from inputs to clk_out or tick.

Decomposition:
- Package clock_divider_pkg:
  - default WIDTH/NCH/DEFAULT_DIV constants;
  - MIN_DIV=2 constant;
  - function hi_threshold(N) = N-(N>>1).
- Sub-module clock_divider_chan (one channel):
  - contains cnt, div, shadow, pending, running, clk_out, tick;
  - inputs: en, sync, load strobe, load value.
- The top level generates NCH instances and implements the cfg_ready mux and cfg_chan decode.

Test Plan:
1. Reset, en=4'b0001, DEFAULT_DIV=4, 20 cycles -> ch0 clk_out pattern after first edge 0,1,1,0,0,1,1,0...; tick on every falling edge; other channels stay 0.
2. ch0 running N=4, write cfg_div=6 mid-period -> busy[0]=1 and cfg_ready=0 for chan 0 until the next wrap. Then period 6 (high 3, low 3) with no pulse shorter than 2 cycles across the change. A second write while busy stalls.
3. Odd divisor: write 3 to ch1 while stopped, then en[1]=1 -> high 1, low 2, period 3; tick every 3 cycles.
4. en[2] dropped at cnt=1 with N=6 -> current period completes (clk_out high 3 cycles), then constant 0. Write cfg_div=1 to a running channel -> stops at its next wrap.
5. ch0 N=4 and ch1 N=6 free-running, sync pulse -> both tick the next cycle; afterwards rising edges align every 12 cycles.
6. nrst=0 mid-period with a pending write -> next cycle all outputs 0, busy=0, div restored to 4; the pending value is lost.
